// File: rtl/anim_datapath_pkg.sv
// Shared constants, pixel record and sub-FSM encoding for the falling-sprite datapath.
package anim_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned BOX      = 4;
  localparam int unsigned STEP     = 1;
  localparam int unsigned BOX_LOG2 = $clog2(BOX);
  localparam int unsigned CNT_W    = 2 * BOX_LOG2;

  localparam logic [2:0] BG_COLOUR = 3'b000;
  localparam logic [2:0] SP_COLOUR = 3'b110;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  localparam logic [7:0] X_MAX   = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX   = 7'(SCREEN_H - 1);
  localparam logic [7:0] SX_SPAN = 8'(SCREEN_W - BOX + 1);
  localparam logic [6:0] SY_LAST = 7'(SCREEN_H - BOX);

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_BG     = 4'd1;
  localparam state_t S_BG_FIN = 4'd2;
  localparam state_t S_LOAD   = 4'd3;
  localparam state_t S_DRAW   = 4'd4;
  localparam state_t S_WAIT   = 4'd5;
  localparam state_t S_ERASE  = 4'd6;
  localparam state_t S_MOVE   = 4'd7;
  localparam state_t S_FIN    = 4'd8;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  // Single conditional subtract is enough: an 8-bit value is below 2*SX_SPAN.
  function automatic logic [7:0] col_from_lfsr(input logic [7:0] r);
    return (r >= SX_SPAN) ? (r - SX_SPAN) : r;
  endfunction

endpackage

// File: rtl/anim_datapath_if.sv
// Control/status and VGA-adapter pixel bus between the game FSM and the datapath.
interface anim_datapath_if;

  logic       ld_BG;
  logic       ld_coord;
  logic       ld_plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       draw;
  logic       done;

  modport master (
    output ld_BG, ld_coord, ld_plot,
    input  x, y, colour, plot, draw, done
  );

  modport slave (
    input  ld_BG, ld_coord, ld_plot,
    output x, y, colour, plot, draw, done
  );

endinterface

// File: rtl/anim_datapath_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4, used to pick the sprite column.
module lfsr8
  import anim_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= LFSR_SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/anim_datapath.sv
// Background sweep and falling-sprite animation datapath driving the VGA adapter.
module anim_datapath
  import anim_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = 833333
)
(
  input  logic              clk,
  input  logic              reset,
  anim_datapath_if.slave    bus
);

  localparam int unsigned WCNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_TICKS - 1);

  logic [7:0]        lfsr;

  state_t            state_q, state_d;
  logic [7:0]        bx_q, bx_d;
  logic [6:0]        by_q, by_d;
  logic [7:0]        sx_q, sx_d;
  logic [6:0]        sy_q, sy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  pixel_t            pix_q, pix_d;
  logic              plot_q, plot_d;
  logic              draw_q, draw_d;
  logic              done_q, done_d;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  // Input priority is encoded by the if/else order: ld_BG, then ld_coord, then ld_plot.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;

    if (bus.ld_BG) begin
      case (state_q)
        S_BG: begin
          if (bx_q == X_MAX && by_q == Y_MAX) begin
            state_d = S_BG_FIN;
          end else if (bx_q == X_MAX) begin
            bx_d = '0;
            by_d = by_q + 7'd1;
          end else begin
            bx_d = bx_q + 8'd1;
          end
        end
        S_BG_FIN: ;
        default: begin
          state_d = S_BG;
          bx_d    = '0;
          by_d    = '0;
        end
      endcase
    end else if (state_q == S_BG || state_q == S_BG_FIN) begin
      state_d = S_IDLE;
      bx_d    = '0;
      by_d    = '0;
    end else if (bus.ld_coord) begin
      state_d = S_LOAD;
      sx_d    = col_from_lfsr(lfsr);
      sy_d    = '0;
    end else if (!bus.ld_plot) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_DRAW: begin
          if (cnt_q == '1) begin
            state_d = S_WAIT;
            wcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (wcnt_q == WCNT_LAST) begin
            state_d = S_ERASE;
            cnt_d   = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        S_ERASE: begin
          if (cnt_q == '1) state_d = S_MOVE;
          else             cnt_d   = cnt_q + CNT_W'(1);
        end
        S_MOVE: begin
          if ((sy_q + 7'(STEP)) > SY_LAST) begin
            state_d = S_FIN;
          end else begin
            state_d = S_DRAW;
            sy_d    = sy_q + 7'(STEP);
            cnt_d   = '0;
          end
        end
        S_FIN: state_d = S_IDLE;
        default: begin
          state_d = S_DRAW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_comb begin
    pix_d  = pix_q;
    plot_d = 1'b0;
    case (state_d)
      S_BG: begin
        pix_d.x      = bx_d;
        pix_d.y      = by_d;
        pix_d.colour = BG_COLOUR;
        plot_d       = 1'b1;
      end
      S_DRAW, S_ERASE: begin
        pix_d.x      = sx_d + 8'(cnt_d[BOX_LOG2-1:0]);
        pix_d.y      = sy_d + 7'(cnt_d[CNT_W-1:BOX_LOG2]);
        pix_d.colour = (state_d == S_DRAW) ? SP_COLOUR : BG_COLOUR;
        plot_d       = 1'b1;
      end
      default: ;
    endcase
    draw_d = (state_d == S_BG_FIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bx_q    <= '0;
      by_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      pix_q   <= '0;
      plot_q  <= 1'b0;
      draw_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      pix_q   <= pix_d;
      plot_q  <= plot_d;
      draw_q  <= draw_d;
      done_q  <= done_d;
    end
  end

  assign bus.x      = pix_q.x;
  assign bus.y      = pix_q.y;
  assign bus.colour = pix_q.colour;
  assign bus.plot   = plot_q;
  assign bus.draw   = draw_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_anim_datapath.sv
// Scoreboard bench for anim_datapath: stimulus queues expected pixel writes, a monitor checks them.
`timescale 1ns/1ps
module tb_anim_datapath;

  localparam int FT = 4;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];
  pix_t mon_e;
  logic [7:0] lfsr_m;

  always #5 clk = ~clk;

  anim_datapath_if bus();

  anim_datapath #(.FRAME_TICKS(FT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.plot) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d, expected no plot",
                   bus.x, bus.y, bus.colour);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.x != mon_e.x || bus.y != mon_e.y || bus.colour != mon_e.c) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                     bus.x, bus.y, bus.colour, mon_e.x, mon_e.y, mon_e.c);
          end
        end
      end
      if (bus.done) begin
        checks++;
        if (bus.draw) begin
          errors++;
          $display("FAIL done_draw_exclusive: got draw=1 with done=1, expected draw=0");
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push_pix(input int x, input int y, input int c);
    pix_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    exp_q.push_back(p);
  endtask

  task automatic push_box(input int sx, input int sy, input int c);
    for (int i = 0; i < 16; i++) push_pix(sx + i % 4, sy + i / 4, c);
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) push_pix(i % 160, i / 160, 0);
  endtask

  // Waits for the reference LFSR to show v (or 8 cycles when v<0), then pulses ld_coord.
  task automatic hunt(input int v, output logic [7:0] seen);
    bit found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (v < 0 ? (i == 7) : (lfsr_m == 8'(v))) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL lfsr_hunt: value %0d not seen in 600 cycles, expected seen", v);
    end
    seen = lfsr_m;
    bus.ld_coord = 1'b1;
  endtask

  task automatic load_and_draw_one(input int v, output int sx);
    logic [7:0] r;
    int done_seen;
    hunt(v, r);
    sx = (r >= 157) ? int'(r) - 157 : int'(r);
    @(negedge clk);
    bus.ld_coord = 1'b0;
    push_box(sx, 0, 6);
    bus.ld_plot = 1'b1;
    repeat (18) @(negedge clk);
    bus.ld_plot = 1'b0;
    @(negedge clk);
    check("plot_after_drop", bus.plot, 0);
    done_seen = bus.done ? 1 : 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("no_done_after_drop", done_seen, 0);
    check("queue_drained_load", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int draw_at;
    int done_at;
    int sx;
    logic [7:0] r;

    bus.ld_BG = 1'b0;
    bus.ld_coord = 1'b0;
    bus.ld_plot = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_x", bus.x, 0);
    check("reset_y", bus.y, 0);
    check("reset_colour", bus.colour, 0);
    check("reset_plot", bus.plot, 0);
    check("reset_draw", bus.draw, 0);
    check("reset_done", bus.done, 0);
    reset = 1'b0;

    // Reset in the middle of a sweep.
    push_sweep(20);
    bus.ld_BG = 1'b1;
    repeat (20) @(negedge clk);
    #1 reset = 1'b1;
    bus.ld_BG = 1'b0;
    #1;
    check("midreset_x", bus.x, 0);
    check("midreset_y", bus.y, 0);
    check("midreset_plot", bus.plot, 0);
    check("midreset_draw", bus.draw, 0);
    check("queue_drained_midreset", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("no_plot_after_reset", bus.plot, 0);

    // Full background sweep.
    push_sweep(19200);
    bus.ld_BG = 1'b1;
    draw_at = 0;
    for (int i = 1; i <= 19300 && draw_at == 0; i++) begin
      @(negedge clk);
      if (bus.draw) draw_at = i;
    end
    check("draw_cycle", draw_at, 19201);
    check("plot_with_draw", bus.plot, 0);
    repeat (3) @(negedge clk);
    check("draw_held", bus.draw, 1);
    bus.ld_BG = 1'b0;
    @(negedge clk);
    check("draw_cleared", bus.draw, 0);
    check("queue_drained_sweep", exp_q.size(), 0);

    // Column picks at a fixed cycle and at the modulo boundaries.
    load_and_draw_one(-1, sx);
    load_and_draw_one(157, sx);
    check("sx_from_157", sx, 0);
    load_and_draw_one(156, sx);
    check("sx_from_156", sx, 156);

    // ld_BG during DRAW abandons the sprite and restarts the sweep at (0,0).
    for (int i = 0; i < 5; i++) push_pix(156 + i % 4, i / 4, 6);
    bus.ld_plot = 1'b1;
    repeat (5) @(negedge clk);
    push_sweep(8);
    bus.ld_BG = 1'b1;
    repeat (8) @(negedge clk);
    bus.ld_BG = 1'b0;
    bus.ld_plot = 1'b0;
    @(negedge clk);
    check("plot_after_bg_abort", bus.plot, 0);
    check("queue_drained_abort", exp_q.size(), 0);

    // Full fall from column 10.
    hunt(10, r);
    @(negedge clk);
    bus.ld_coord = 1'b0;
    for (int f = 0; f < 117; f++) begin
      push_box(10, f, 6);
      push_box(10, f, 0);
    end
    bus.ld_plot = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 4400 && done_at == 0; i++) begin
      @(negedge clk);
      if (i == 17 || i == 20) check("wait_gap_plot", bus.plot, 0);
      if (i == 21) check("erase_start_plot", bus.plot, 1);
      if (i == 37) check("move_plot", bus.plot, 0);
      if (i == 38) check("frame2_y", bus.y, 1);
      if (bus.done) done_at = i;
    end
    check("done_cycle", done_at, 4330);
    bus.ld_plot = 1'b0;
    @(negedge clk);
    check("done_width", bus.done, 0);
    check("idle_plot_after_done", bus.plot, 0);
    repeat (5) @(negedge clk);
    check("queue_drained_fall", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
